// File: rtl/keypad_hex_entry_pkg.sv
// Shared definitions for the hex keypad entry block: FSM states, key codes,
// row-drive pattern and the frame decoder used to pick a single pressed key.
package keypad_hex_entry_pkg;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hF;
  localparam logic [3:0] ROW_IDLE  = 4'b1110;

  typedef struct packed {
    logic       empty;
    logic       single;
    logic [3:0] code;
  } frame_info_t;

  // Frame bit 4r+c is key {r,c}, so the bit index is the key code itself.
  function automatic frame_info_t decode_frame(input logic [15:0] frame);
    frame_info_t info;
    int unsigned hits;
    hits        = 0;
    info.empty  = (frame == 16'h0000);
    info.code   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        hits++;
        info.code = 4'(i);
      end
    end
    info.single = (hits == 1);
    return info;
  endfunction

endpackage

// File: rtl/keypad_hex_entry_row_scanner.sv
// Row scanner for a 4x4 active-low keypad: drives one row low per dwell
// period, synchronises the columns and assembles a 16-bit pressed-key frame.
module keypad_row_scanner #(
  parameter int SCAN_DIV = 49999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col_i,
  output logic [3:0]  row_o,
  output logic [15:0] frame,
  output logic        frame_done
);
  import keypad_hex_entry_pkg::*;

  localparam int DW = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;

  logic [3:0]    col_meta;
  logic [3:0]    col_sync;
  logic [DW-1:0] dwell_cnt;
  logic [1:0]    row_idx;
  logic [11:0]   frame_acc;
  logic          last_dwell;

  // Synchroniser flops idle high so nothing looks pressed straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col_i;
      col_sync <= col_meta;
    end
  end

  assign last_dwell = (dwell_cnt == DW'(SCAN_DIV));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_cnt <= '0;
      row_idx   <= 2'd0;
      frame_acc <= '0;
    end else if (last_dwell) begin
      dwell_cnt <= '0;
      row_idx   <= row_idx + 2'd1;
      case (row_idx)
        2'd0:    frame_acc[3:0]  <= ~col_sync;
        2'd1:    frame_acc[7:4]  <= ~col_sync;
        2'd2:    frame_acc[11:8] <= ~col_sync;
        default: ;
      endcase
    end else begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end
  end

  // The last row is not stored; it is combined live on the completing cycle.
  assign frame      = {~col_sync, frame_acc};
  assign frame_done = last_dwell && (row_idx == 2'd3);

  always_comb begin
    row_o = ROW_IDLE;
    case (row_idx)
      2'd1:    row_o = 4'b1101;
      2'd2:    row_o = 4'b1011;
      2'd3:    row_o = 4'b0111;
      default: row_o = ROW_IDLE;
    endcase
  end

endmodule

// File: rtl/keypad_hex_entry.sv
// Debounced 4x4 hex keypad entry with a 32-bit digit register and CPU req/ack.
// Optional KEYPAD_CLEAR_KEY_EN makes key F clear the entry register.
module keypad_hex_entry #(
  parameter int SCAN_DIV       = 49999,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row_o,
  input  logic [3:0]  col_i,
  output logic [3:0]  key_code_o,
  output logic        key_req_o,
  input  logic        key_ack_i,
  output logic        overrun_o,
  output logic [31:0] value_o
);
  import keypad_hex_entry_pkg::*;

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_SCANS);

  logic [15:0] frame;
  logic        frame_done;
  frame_info_t info;

  state_t      state, state_n;
  logic [3:0]  cand, cand_n;
  logic [3:0]  cnt, cnt_n, cnt_inc;
  logic        accept;

  keypad_row_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
    .clk        (clk),
    .rst        (rst),
    .col_i      (col_i),
    .row_o      (row_o),
    .frame      (frame),
    .frame_done (frame_done)
  );

  assign info = decode_frame(frame);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SCAN;
      cand  <= 4'h0;
      cnt   <= 4'h0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  // Debounce decisions happen only on frame completion; between frames the
  // FSM simply holds.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    cnt_inc = cnt + 4'd1;
    accept  = 1'b0;
    if (frame_done) begin
      case (state)
        SCAN: begin
          if (info.single) begin
            cand_n = info.code;
            if (DEB_LAST == 4'd1) begin
              accept  = 1'b1;
              state_n = HELD;
              cnt_n   = 4'd0;
            end else begin
              state_n = DEB_PRESS;
              cnt_n   = 4'd1;
            end
          end
        end
        DEB_PRESS: begin
          if (info.single && (info.code == cand)) begin
            if (cnt_inc == DEB_LAST) begin
              accept  = 1'b1;
              state_n = HELD;
              cnt_n   = 4'd0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = SCAN;
            cnt_n   = 4'd0;
          end
        end
        HELD: begin
          if (info.empty) begin
            if (DEB_LAST == 4'd1) begin
              state_n = SCAN;
              cnt_n   = 4'd0;
            end else begin
              state_n = DEB_REL;
              cnt_n   = 4'd1;
            end
          end
        end
        DEB_REL: begin
          if (info.empty) begin
            if (cnt_inc == DEB_LAST) begin
              state_n = SCAN;
              cnt_n   = 4'd0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = HELD;
            cnt_n   = 4'd0;
          end
        end
        default: begin
          state_n = SCAN;
          cnt_n   = 4'd0;
        end
      endcase
    end
  end

  // An accept always wins over a same-cycle ack; overrun only flags a key
  // that lands on a request the CPU has not yet consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code_o <= 4'h0;
      key_req_o  <= 1'b0;
      overrun_o  <= 1'b0;
      value_o    <= 32'h0;
    end else if (accept) begin
      key_code_o <= info.code;
`ifdef KEYPAD_CLEAR_KEY_EN
      value_o    <= (info.code == KEY_CLEAR) ? 32'h0 : {value_o[27:0], info.code};
`else
      value_o    <= {value_o[27:0], info.code};
`endif
      key_req_o  <= 1'b1;
      if (key_req_o && !key_ack_i) begin
        overrun_o <= 1'b1;
      end
    end else if (key_ack_i && key_req_o) begin
      key_req_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Scoreboard bench for keypad_hex_entry with a behavioural 4x4 keypad model.
// Runs with SCAN_DIV=3, DEBOUNCE_SCANS=2 so one frame is 16 clocks.
module tb_keypad_hex_entry;

  localparam int SCAN_DIV       = 3;
  localparam int DEBOUNCE_SCANS = 2;
  localparam int FRAME          = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_o;
  logic [3:0]  col_i;
  logic [3:0]  key_code_o;
  logic        key_req_o;
  logic        key_ack_i;
  logic        overrun_o;
  logic [31:0] value_o;

  logic [15:0] keys;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] value;
    logic        overrun;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_value;
  logic        model_req;
  logic        model_overrun;
  int          n_checks = 0;
  int          n_fails  = 0;

  keypad_hex_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) dut (
    .clk        (clk),
    .rst        (rst),
    .row_o      (row_o),
    .col_i      (col_i),
    .key_code_o (key_code_o),
    .key_req_o  (key_req_o),
    .key_ack_i  (key_ack_i),
    .overrun_o  (overrun_o),
    .value_o    (value_o)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its column low whenever its row is driven low.
  always_comb begin
    col_i = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_o[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (keys[4*r+c]) col_i[c] = 1'b0;
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    model_value   = 32'h0;
    model_req     = 1'b0;
    model_overrun = 1'b0;
    sb.delete();
  endtask

  task automatic expect_accept(input logic [3:0] code);
    exp_t e;
    if (model_req) model_overrun = 1'b1;
    model_req = 1'b1;
`ifdef KEYPAD_CLEAR_KEY_EN
    model_value = (code == 4'hF) ? 32'h0 : {model_value[27:0], code};
`else
    model_value = {model_value[27:0], code};
`endif
    e.code    = code;
    e.value   = model_value;
    e.overrun = model_overrun;
    sb.push_back(e);
  endtask

  // Called on a frame-start cycle; returns on the cycle the accept takes effect.
  task automatic drive_press(input logic [3:0] code);
    keys = 16'h0001 << code;
    expect_accept(code);
    wait_cycles(2 * FRAME);
  endtask

  // Releases for two frames, optionally acking in the first cycle.
  task automatic release_key(input logic do_ack);
    keys = 16'h0000;
    if (do_ack) begin
      key_ack_i = 1'b1;
      wait_cycles(1);
      key_ack_i = 1'b0;
      model_req = 1'b0;
      wait_cycles(2 * FRAME - 1);
    end else begin
      wait_cycles(2 * FRAME);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    keys = 16'h0000;
    key_ack_i = 1'b0;
    model_reset();
    wait_cycles(2);
    n_checks++; if (row_o !== 4'b1110) begin n_fails++; $display("[TB] FAIL rst_row: got %b expected %b", row_o, 4'b1110); end
    n_checks++; if (key_code_o !== 4'h0) begin n_fails++; $display("[TB] FAIL rst_code: got %h expected %h", key_code_o, 4'h0); end
    n_checks++; if (key_req_o !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_req: got %b expected %b", key_req_o, 1'b0); end
    n_checks++; if (overrun_o !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_ovr: got %b expected %b", overrun_o, 1'b0); end
    n_checks++; if (value_o !== 32'h0) begin n_fails++; $display("[TB] FAIL rst_value: got %h expected %h", value_o, 32'h0); end
    rst = 1'b0;
  endtask

  task automatic test_single_key();
    exp_t e;
    keys = 16'h0001 << 6;
    expect_accept(4'h6);
    wait_cycles(2 * FRAME - 1);
    n_checks++; if (key_req_o !== 1'b0) begin n_fails++; $display("[TB] FAIL single_early_req: got %b expected %b", key_req_o, 1'b0); end
    n_checks++; if (value_o !== 32'h0) begin n_fails++; $display("[TB] FAIL single_early_value: got %h expected %h", value_o, 32'h0); end
    wait_cycles(1);
    if (sb.size() == 0) begin
      n_checks++; n_fails++; $display("[TB] FAIL single_sb: got empty expected entry");
    end else begin
      e = sb.pop_front();
      n_checks++; if (key_code_o !== e.code) begin n_fails++; $display("[TB] FAIL single_code: got %h expected %h", key_code_o, e.code); end
      n_checks++; if (value_o !== e.value) begin n_fails++; $display("[TB] FAIL single_value: got %h expected %h", value_o, e.value); end
      n_checks++; if (key_req_o !== 1'b1) begin n_fails++; $display("[TB] FAIL single_req: got %b expected %b", key_req_o, 1'b1); end
      n_checks++; if (overrun_o !== e.overrun) begin n_fails++; $display("[TB] FAIL single_ovr: got %b expected %b", overrun_o, e.overrun); end
    end
    wait_cycles(FRAME);
    n_checks++; if (value_o !== 32'h00000006) begin n_fails++; $display("[TB] FAIL held_value: got %h expected %h", value_o, 32'h6); end
    n_checks++; if (overrun_o !== 1'b0) begin n_fails++; $display("[TB] FAIL held_ovr: got %b expected %b", overrun_o, 1'b0); end
    release_key(1'b1);
    n_checks++; if (key_req_o !== model_req) begin n_fails++; $display("[TB] FAIL single_ack: got %b expected %b", key_req_o, model_req); end
  endtask

  task automatic test_sequence();
    exp_t e;
    for (int k = 1; k <= 9; k++) begin
      drive_press(4'(k));
      if (sb.size() == 0) begin
        n_checks++; n_fails++; $display("[TB] FAIL seq_sb: got empty expected entry");
      end else begin
        e = sb.pop_front();
        n_checks++; if (key_code_o !== e.code) begin n_fails++; $display("[TB] FAIL seq_code[%0d]: got %h expected %h", k, key_code_o, e.code); end
        n_checks++; if (value_o !== e.value) begin n_fails++; $display("[TB] FAIL seq_value[%0d]: got %h expected %h", k, value_o, e.value); end
        n_checks++; if (key_req_o !== 1'b1) begin n_fails++; $display("[TB] FAIL seq_req[%0d]: got %b expected %b", k, key_req_o, 1'b1); end
      end
      release_key(1'b1);
      n_checks++; if (key_req_o !== 1'b0) begin n_fails++; $display("[TB] FAIL seq_ack[%0d]: got %b expected %b", k, key_req_o, 1'b0); end
    end
    n_checks++; if (value_o !== 32'h23456789) begin n_fails++; $display("[TB] FAIL seq_final: got %h expected %h", value_o, 32'h23456789); end
    n_checks++; if (overrun_o !== 1'b0) begin n_fails++; $display("[TB] FAIL seq_ovr: got %b expected %b", overrun_o, 1'b0); end
  endtask

  task automatic test_overrun();
    exp_t e;
    drive_press(4'h3);
    e = sb.pop_front();
    n_checks++; if (overrun_o !== e.overrun) begin n_fails++; $display("[TB] FAIL ovr_first: got %b expected %b", overrun_o, e.overrun); end
    release_key(1'b0);
    drive_press(4'hA);
    e = sb.pop_front();
    n_checks++; if (key_code_o !== e.code) begin n_fails++; $display("[TB] FAIL ovr_code: got %h expected %h", key_code_o, e.code); end
    n_checks++; if (value_o !== e.value) begin n_fails++; $display("[TB] FAIL ovr_value: got %h expected %h", value_o, e.value); end
    n_checks++; if (value_o[7:0] !== 8'h3A) begin n_fails++; $display("[TB] FAIL ovr_digits: got %h expected %h", value_o[7:0], 8'h3A); end
    n_checks++; if (key_req_o !== 1'b1) begin n_fails++; $display("[TB] FAIL ovr_req: got %b expected %b", key_req_o, 1'b1); end
    n_checks++; if (overrun_o !== 1'b1) begin n_fails++; $display("[TB] FAIL ovr_flag: got %b expected %b", overrun_o, 1'b1); end
    release_key(1'b1);
    n_checks++; if (overrun_o !== 1'b1) begin n_fails++; $display("[TB] FAIL ovr_sticky: got %b expected %b", overrun_o, 1'b1); end
    n_checks++; if (key_req_o !== 1'b0) begin n_fails++; $display("[TB] FAIL ovr_ack: got %b expected %b", key_req_o, 1'b0); end
  endtask

  task automatic test_chatter();
    for (int a = 0; a < 3; a++) begin
      keys = 16'h0001 << (a + 1);
      wait_cycles(FRAME);
      keys = 16'h0000;
      wait_cycles(FRAME);
      n_checks++; if (key_req_o !== 1'b0) begin n_fails++; $display("[TB] FAIL chatter_req[%0d]: got %b expected %b", a, key_req_o, 1'b0); end
      n_checks++; if (value_o !== model_value) begin n_fails++; $display("[TB] FAIL chatter_value[%0d]: got %h expected %h", a, value_o, model_value); end
    end
    keys = 16'h0001 << 2;
    wait_cycles(FRAME);
    keys = 16'h0001 << 7;
    wait_cycles(2 * FRAME);
    n_checks++; if (key_req_o !== 1'b0) begin n_fails++; $display("[TB] FAIL switch_req: got %b expected %b", key_req_o, 1'b0); end
    keys = 16'h0000;
    wait_cycles(2 * FRAME);
    keys = (16'h0001 << 1) | (16'h0001 << 5);
    wait_cycles(3 * FRAME);
    n_checks++; if (key_req_o !== 1'b0) begin n_fails++; $display("[TB] FAIL multi_req: got %b expected %b", key_req_o, 1'b0); end
    n_checks++; if (value_o !== model_value) begin n_fails++; $display("[TB] FAIL multi_value: got %h expected %h", value_o, model_value); end
    keys = 16'h0000;
    wait_cycles(2 * FRAME);
    n_checks++; if (sb.size() != 0) begin n_fails++; $display("[TB] FAIL chatter_sb: got %0d expected %0d", sb.size(), 0); end
  endtask

  task automatic test_reset_mid_debounce();
    exp_t e;
    keys = 16'h0001 << 9;
    wait_cycles(FRAME + 5);
    rst = 1'b1;
    wait_cycles(1);
    n_checks++; if (row_o !== 4'b1110) begin n_fails++; $display("[TB] FAIL mid_rst_row: got %b expected %b", row_o, 4'b1110); end
    n_checks++; if (key_code_o !== 4'h0) begin n_fails++; $display("[TB] FAIL mid_rst_code: got %h expected %h", key_code_o, 4'h0); end
    n_checks++; if (overrun_o !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_rst_ovr: got %b expected %b", overrun_o, 1'b0); end
    n_checks++; if (value_o !== 32'h0) begin n_fails++; $display("[TB] FAIL mid_rst_value: got %h expected %h", value_o, 32'h0); end
    n_checks++; if (key_req_o !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_rst_req: got %b expected %b", key_req_o, 1'b0); end
    wait_cycles(1);
    rst = 1'b0;
    model_reset();
    expect_accept(4'h9);
    wait_cycles(2 * FRAME - 1);
    n_checks++; if (key_req_o !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_early_req: got %b expected %b", key_req_o, 1'b0); end
    wait_cycles(1);
    e = sb.pop_front();
    n_checks++; if (key_req_o !== 1'b1) begin n_fails++; $display("[TB] FAIL mid_req: got %b expected %b", key_req_o, 1'b1); end
    n_checks++; if (key_code_o !== e.code) begin n_fails++; $display("[TB] FAIL mid_code: got %h expected %h", key_code_o, e.code); end
    n_checks++; if (value_o !== e.value) begin n_fails++; $display("[TB] FAIL mid_value: got %h expected %h", value_o, e.value); end
    release_key(1'b1);
  endtask

  task automatic test_clear_key();
    exp_t e;
    rst = 1'b1;
    keys = 16'h0000;
    model_reset();
    wait_cycles(2);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive_press(4'(k));
      e = sb.pop_front();
      n_checks++; if (value_o !== e.value) begin n_fails++; $display("[TB] FAIL clr_prep[%0d]: got %h expected %h", k, value_o, e.value); end
      release_key(1'b1);
    end
    n_checks++; if (value_o !== 32'h1234) begin n_fails++; $display("[TB] FAIL clr_base: got %h expected %h", value_o, 32'h1234); end
    drive_press(4'hF);
    e = sb.pop_front();
    n_checks++; if (value_o !== e.value) begin n_fails++; $display("[TB] FAIL clr_value: got %h expected %h", value_o, e.value); end
`ifdef KEYPAD_CLEAR_KEY_EN
    n_checks++; if (value_o !== 32'h0) begin n_fails++; $display("[TB] FAIL clr_zero: got %h expected %h", value_o, 32'h0); end
`else
    n_checks++; if (value_o !== 32'h1234F) begin n_fails++; $display("[TB] FAIL clr_shift: got %h expected %h", value_o, 32'h1234F); end
`endif
    n_checks++; if (key_code_o !== 4'hF) begin n_fails++; $display("[TB] FAIL clr_code: got %h expected %h", key_code_o, 4'hF); end
    n_checks++; if (key_req_o !== 1'b1) begin n_fails++; $display("[TB] FAIL clr_req: got %b expected %b", key_req_o, 1'b1); end
    n_checks++; if (overrun_o !== e.overrun) begin n_fails++; $display("[TB] FAIL clr_ovr: got %b expected %b", overrun_o, e.overrun); end
    release_key(1'b1);
  endtask

  initial begin
    rst = 1'b1;
    keys = 16'h0000;
    key_ack_i = 1'b0;
    test_reset();
    test_single_key();
    test_sequence();
    test_overrun();
    test_chatter();
    test_reset_mid_debounce();
    test_clear_key();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
